iter_shift_ctrl: RTL
====================

Name: iter_shift_ctrl

Overview:
- Sequences a multi-cycle, 1-bit-per-step shift datapath in the execute stage.
- Serves shift instructions (SLL/SRL/SRA/ROL) whose amount is a register value rather than a fixed constant.
- Accepts one operation via a valid/ready handshake, iterates the shift under an FSM and down-counter, then presents the result via a valid/ready handshake.
- Supports pipeline flush, which aborts an in-flight operation.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W = WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept an operation.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left).
- data_in  input  WIDTH  operand.
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- flush  input  1  synchronous abort from the pipeline hazard unit.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- data_out  output  WIDTH  result, registered.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; data_out = 0; out_valid = 0; busy = 0; counter = 0; captured op = 00.
  - Reset is honoured at any point, including mid-shift. The in-flight operation is discarded and no result is produced.
- in_ready is combinational: (state == IDLE) && !flush.
  - No transfer occurs while rst_n is low, because the flops are held.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On in_valid && in_ready: capture data_in into the working register, op into the op register, and shamt into the counter.
  - If shamt == 0, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT: each cycle, apply one 1-bit step to the working register and decrement the counter.
  - SLL: shift left, LSB filled with 0.
  - SRL: shift right, MSB filled with 0.
  - SRA: shift right, MSB replicated.
  - ROL: shift left, old MSB moved into the LSB.
  - When the counter is 1 at the clock edge, perform the last step and go to DONE.
- DONE: out_valid = 1 and data_out = working register.
  - data_out and out_valid are held stable until out_ready is sampled high.
  - On out_valid && out_ready, go to IDLE with out_valid cleared on the same edge.
- Latency from the accepting edge to out_valid high:
  - shamt + 1 cycles (shamt = 0 gives 1 cycle; shamt = 31 gives 32 cycles).
  - With out_ready held high, throughput is one operation per shamt + 2 cycles.
- No overlap: a new request cannot be accepted in the cycle a result is consumed. in_ready rises the cycle after the DONE→IDLE transition.
- Flush (synchronous, highest priority):
  - In any state, flush high at a clock edge forces IDLE, clears out_valid, and clears the counter.
  - data_out keeps its last value.
  - Flush in DONE together with out_ready: the result is treated as not delivered. The consumer must ignore it because flush wins.
  - Flush in IDLE together with in_valid: the request is not accepted.
- Arithmetic: all steps are exactly WIDTH bits, with no carry-out or overflow flag.
- shamt is sampled only at acceptance; later changes on the input are ignored.
- busy = (state != IDLE).

Test Plan:
- SLL, data_in = 0x00000001, shamt = 2, out_ready = 1 -> out_valid high 3 cycles after accept, data_out = 0x00000004, in_ready back high 2 cycles later.
- SRA 0x80000000 by 31 -> 0xFFFFFFFF after 32 cycles. SRL 0x80000000 by 31 -> 0x00000001. ROL 0x80000001 by 4 -> 0x00000018.
- shamt = 0, op = SRL, data_in = 0xDEADBEEF -> data_out = 0xDEADBEEF with out_valid 1 cycle after accept. busy is high for exactly 1 cycle plus any backpressure.
- Backpressure: out_ready low for 5 cycles in DONE -> out_valid and data_out stable, in_ready low throughout. Result consumed on the first out_ready-high edge. in_valid held high by a second requester is accepted only the cycle after.
- Flush at cycle 3 of a 10-step SLL -> IDLE next edge, out_valid never asserted, next request (SRL 0xF0 by 4) yields 0x0F correctly. Flush with in_valid in IDLE -> no accept.
- rst_n pulsed low mid-SHIFT, asynchronously between clock edges -> outputs 0 immediately, state IDLE. After release the first accepted op completes with correct latency.

Source files
------------

// File: rtl/iter_shift_ctrl.sv
// Iterative 1-bit-per-cycle shifter (SLL/SRL/SRA/ROL) for register shift amounts.
// A valid/ready handshake on each side, with flush aborting an in-flight operation.
module iter_shift_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [1:0]         op_q, op_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   stepped;

    function automatic logic [WIDTH-1:0] step1(input logic [1:0] o, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v;
        case (o)
            2'b00:   r = {v[WIDTH-2:0], 1'b0};
            2'b01:   r = {1'b0, v[WIDTH-1:1]};
            2'b10:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = {v[WIDTH-2:0], v[WIDTH-1]};
        endcase
        return r;
    endfunction

    assign stepped = step1(op_q, work_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            dout_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            dout_q  <= dout_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // The result register is loaded on the edge that enters DONE, so it stays
    // frozen through backpressure and keeps its last value after a flush.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        dout_d  = dout_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_d = data_in;
                        op_d   = op;
                        cnt_d  = shamt;
                        if (shamt == '0) begin
                            state_d = DONE;
                            dout_d  = data_in;
                        end else begin
                            state_d = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_d = stepped;
                    cnt_d  = cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_d = DONE;
                        dout_d  = stepped;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !flush;
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        data_out  = dout_q;
    end

endmodule
